sd_cmd_seq: RTL
===============

# sd_cmd_seq

SD-card command-line sequencer for the chip_top SD host path. It generates the SD clock and serialises a 48-bit command frame (start bit, transmission bit, index, argument, CRC7, end bit) onto the bidirectional CMD line. It then waits for and captures the card's 48-bit or 136-bit response, and reports completion, timeout or CRC error to the SD host register block.

## Interface

Parameters:
- CLK_DIV, 4: SD clock half-period in `clk` cycles (≥1); sd_sclk = clk/(2*CLK_DIV).
- TIMEOUT, 64: max sd_sclk rising edges waited for a response start bit (NCR).

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset; asynchronous, active-low.
- start  in  1  command request; sampled only in IDLE.
- cmd_index  in  6  command index.
- cmd_arg  in  32  command argument.
- resp_type  in  2  0 none, 1 short (48 b), 2 long (136 b), 3 treated as 1.
- busy  out  1  high from accepted start until done.
- done  out  1  one-`clk` completion pulse.
- timeout  out  1  status of last command; valid with done, held until next start.
- crc_err  out  1  status of last command; valid with done, held until next start.
- resp  out  134  received bits after start bit, excluding end bit, right-justified.
- sd_sclk  out  1  SD clock.
- sd_cmd_o  out  1  CMD drive value.
- sd_cmd_oe  out  1  CMD output enable.
- sd_cmd_i  in  1  CMD line input (pulled high when undriven).

## Operation

- Clock generator: counter 0..CLK_DIV-1 runs continuously after reset. On wrap, sd_sclk toggles. Toggle 0→1 produces a `rise` tick; toggle 1→0 produces a `fall` tick.
- Frame: {1'b0, 1'b1, cmd_index, cmd_arg, crc7, 1'b1}, MSB first. crc7 uses polynomial x^7+x^3+1 over the first 40 bits, with initial value 0.
- FSM:
  - IDLE: on start, latch index/arg/type, compute CRC, clear timeout/crc_err/resp, set busy → TX.
  - TX: on each `fall`, drive next bit with oe=1. After the 48th bit has been held for one full sd_sclk period, oe=0 at the next `fall`. Go to GAP if resp_type=0, else WAIT.
  - WAIT: count `rise` ticks. If sd_cmd_i=0 at a rise → RX. If the count reaches TIMEOUT → timeout=1, GAP.
  - RX: shift sd_cmd_i in on each `rise`. Collect 46 bits (short) or 134 bits (long), then sample one more rise as end bit → GAP.
  - GAP: 8 sd_sclk periods (NRC/NCC) with oe=0 → IDLE, pulse done, drop busy in the same `clk`.
- Short response: resp[45:0] = {trans, index, arg, crc7}; resp[133:46] = 0.
- CRC check (short only): recompute CRC7 over the start bit plus the first 39 captured bits and compare with resp[6:0]. Long responses never set crc_err.
- End bit sampled as 0: crc_err=1 (framing), regardless of configuration.
- start while busy: ignored, no queueing.

## Timing

- Reset values: busy 0, done 0, timeout 0, crc_err 0, resp 0, sd_sclk 0, sd_cmd_o 1, sd_cmd_oe 0, FSM IDLE, divider 0.
- Reset assertion mid-command: all outputs return to their reset values asynchronously. The CMD line is released immediately.
- First frame bit is driven on the first `fall` after start acceptance (≤ 2*CLK_DIV+1 clk).
- Command-only latency: 48 + 1 + 8 sd_sclk periods ± 1 period, start to done.
- Response bits are sampled on `rise`; command bits change on `fall`.
- done coincides with busy falling. resp/timeout/crc_err are stable from done until the next accepted start.

## Configuration

- SD_CMD_CRC_CHECK_EN defined: CRC7 comparison on short responses as above.
- Undefined: the response CRC logic is omitted. crc_err is set only by an end-bit error. Command CRC generation is always present.

## Test plan

- CMD0, arg 0, resp_type 0, CLK_DIV 4 → CMD bits 0x40_00000000_95 observed on sd_cmd_o at sd_sclk falls. done 57±1 sd_sclk periods after start. timeout=0.
- CMD8, arg 0x000001AA, type 1; card model returns R7 0x08_000001AA_13 → frame CRC 0x87 sent. resp[45:0] = {1'b0, 6'd8, 32'h1AA, 7'h09}. crc_err=0.
- Same as the previous case with the response CRC bit 0 flipped → crc_err=1 with SD_CMD_CRC_CHECK_EN, 0 without. done still pulses.
- CMD55, type 1, card never drives CMD → timeout=1 after 64 rises. resp=0. oe never reasserts.
- CMD2, type 2, 136-bit CID response → resp[133:0] matches the model. crc_err=0. Second start during busy is ignored (single done).
- rstn pulsed low mid-TX at bit 20 → sd_cmd_oe=0 and busy=0 asynchronously. A new CMD0 after reset completes normally.

Source files
------------

// File: rtl/sd_cmd_seq.sv
// sd_cmd_seq: SD-card CMD-line sequencer.
// Generates sd_sclk from clk. Serialises a 48-bit command frame
// {0,1,index,arg,crc7,1} MSB first on sd_sclk falls. It then waits for a
// response start bit, shifts the response in on sd_sclk rises, and reports
// done, timeout or crc_err.
//
// Ports
//   clk, rstn          system clock, asynchronous active-low reset
//   start              command request (only looked at while idle)
//   cmd_index/cmd_arg  command index and argument
//   resp_type          0 none, 1 short 48 b, 2 long 136 b, 3 same as 1
//   busy / done        busy from accepted start; done pulses as busy drops
//   timeout / crc_err  status of last command, held until the next start
//   resp               response bits after start bit, end bit excluded,
//                      right-justified
//   sd_sclk            SD clock, clk / (2*CLK_DIV)
//   sd_cmd_o/_oe/_i    CMD line drive value, output enable, input
//
// Build option: define SD_CMD_CRC_CHECK_EN to check CRC7 on short responses.
// Without it, crc_err only flags a bad end bit.
//
// state  | meaning
// -------+---------------------------------------------------------
// S_IDLE | waiting for start, CMD released
// S_TX   | shifting the 48-bit frame out on sd_sclk falls
// S_WAIT | counting rises until the card's start bit or TIMEOUT
// S_RX   | shifting response bits in on rises, then the end bit
// S_GAP  | 8 sd_sclk periods of idle line before done
module sd_cmd_seq #(
  parameter int CLK_DIV = 4,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   resp_type,
  output logic         busy,
  output logic         done,
  output logic         timeout,
  output logic         crc_err,
  output logic [133:0] resp,
  output logic         sd_sclk,
  output logic         sd_cmd_o,
  output logic         sd_cmd_oe,
  input  logic         sd_cmd_i
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_TX, S_WAIT, S_RX, S_GAP} state_t;
  state_t state, state_nxt;

  logic [DIV_W-1:0] div_cnt;
  logic             wrap, rise, fall, tick;
  logic [47:0]      tx_sr;
  logic [5:0]       tx_left;
  logic [TO_W-1:0]  wait_cnt;
  logic [7:0]       rx_left;
  logic [4:0]       gap_left;
  logic             rsp_none, rsp_long;
  logic             resp_crc_bad;

  // CRC7, x^7 + x^3 + 1, zero initial value, MSB first.
  function automatic logic [6:0] crc7_40(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // Free-running divider. Rise and fall are one-clk ticks that coincide
  // with the clk edge where sd_sclk actually toggles.
  assign wrap = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign rise = wrap & ~sd_sclk;
  assign fall = wrap & sd_sclk;
  assign tick = rise | fall;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt <= '0;
      sd_sclk <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      sd_sclk <= ~sd_sclk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

`ifdef SD_CMD_CRC_CHECK_EN
  // The start bit is 0 and is not stored. Prefixing it keeps the CRC input
  // at 40 bits, the same as the command side.
  assign resp_crc_bad = !rsp_long && (crc7_40({1'b0, resp[45:7]}) != resp[6:0]);
`else
  assign resp_crc_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_TX;
      S_TX:   if (fall && tx_left == 6'd0) state_nxt = rsp_none ? S_GAP : S_WAIT;
      S_WAIT: begin
        if (rise) begin
          if (!sd_cmd_i)                     state_nxt = S_RX;
          else if (wait_cnt == TO_W'(1))     state_nxt = S_GAP;
        end
      end
      S_RX:   if (rise && rx_left == 8'd0) state_nxt = S_GAP;
      S_GAP:  if (tick && gap_left == 5'd1) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      crc_err   <= 1'b0;
      resp      <= '0;
      sd_cmd_o  <= 1'b1;
      sd_cmd_oe <= 1'b0;
      tx_sr     <= '0;
      tx_left   <= '0;
      wait_cnt  <= '0;
      rx_left   <= '0;
      gap_left  <= '0;
      rsp_none  <= 1'b0;
      rsp_long  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            tx_sr    <= {2'b01, cmd_index, cmd_arg,
                         crc7_40({2'b01, cmd_index, cmd_arg}), 1'b1};
            tx_left  <= 6'd48;
            rsp_none <= (resp_type == 2'd0);
            rsp_long <= (resp_type == 2'd2);
            timeout  <= 1'b0;
            crc_err  <= 1'b0;
            resp     <= '0;
            busy     <= 1'b1;
          end
        end
        S_TX: begin
          if (fall) begin
            if (tx_left != 6'd0) begin
              sd_cmd_o  <= tx_sr[47];
              sd_cmd_oe <= 1'b1;
              tx_sr     <= {tx_sr[46:0], 1'b1};
              tx_left   <= tx_left - 6'd1;
            end else begin
              // End bit has had a full period on the line; release CMD.
              sd_cmd_o  <= 1'b1;
              sd_cmd_oe <= 1'b0;
              wait_cnt  <= TO_W'(TIMEOUT);
              // 16 ticks = 8 full sd_sclk periods regardless of entry phase.
              gap_left  <= 5'd16;
            end
          end
        end
        S_WAIT: begin
          if (rise) begin
            if (!sd_cmd_i)                  rx_left  <= rsp_long ? 8'd134 : 8'd46;
            else if (wait_cnt == TO_W'(1))  timeout  <= 1'b1;
            else                            wait_cnt <= wait_cnt - TO_W'(1);
          end
        end
        S_RX: begin
          if (rise) begin
            if (rx_left != 8'd0) begin
              resp    <= {resp[132:0], sd_cmd_i};
              rx_left <= rx_left - 8'd1;
            end else if (!sd_cmd_i || resp_crc_bad) begin
              crc_err <= 1'b1;
            end
          end
        end
        S_GAP: begin
          if (tick) begin
            gap_left <= gap_left - 5'd1;
            if (gap_left == 5'd1) begin
              done <= 1'b1;
              busy <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
